cb8_search: RTL and testbench
=============================

// Module: cb8_search
// PURPOSE
//   Codebook search engine; reads the 8-entry LSP codebook ROM (cb8) and returns the index nearest a target.
//   Scans the ROM sequentially, one entry per clock; keeps the running minimum absolute error.
//   Sits inside cbselect between the LSP computation and the bit packer of the 2400 encoder.
//   The ROM is external and combinational: addr -> dataout in the same cycle.
// PARAMETERS
//   N        32  data width, signed two's-complement fixed point Q15.16 (1 sign, 15 int, 16 frac)
//   CB_SIZE  8   number of codebook entries scanned (addresses 0..CB_SIZE-1)
//   ADDR_W   4   ROM address / index width
// PORTS
//   clk             in   1       system clock, rising edge
//   rst_n           in   1       asynchronous, active-low reset
//   start_cbsearch  in   1       start request; sampled only in IDLE
//   target          in   N       value to quantise; latched on accepted start
//   rom_addr        out  ADDR_W  address to codebook ROM
//   rom_data        in   N       ROM dataout for rom_addr (same cycle)
//   busy            out  1       high from accepted start until done_cbsearch pulse inclusive
//   best_index      out  ADDR_W  index of nearest entry; valid when done_cbsearch=1, held until next start
//   best_error      out  N       |target - cb[best_index]|, Q15.16, saturated; valid and held as best_index
//   done_cbsearch   out  1       one-cycle completion pulse
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; rom_addr=0, busy=0, best_index=0, best_error=0, done_cbsearch=0.
//   States: IDLE -> SEARCH -> DONE -> IDLE.
//   IDLE: start_cbsearch=1 at edge E0 causes these updates:
//     - latch target; rom_addr<=0; min_err<=32'h7FFF_FFFF; best<=0; busy<=1; go SEARCH.
//   SEARCH (edges E1..E_CB_SIZE, one entry per edge):
//     - diff = target - rom_data, computed at N+1 bits; err = |diff|, saturated to 32'h7FFF_FFFF if > max.
//     - If err < min_err (strict), update min_err<=err and best<=rom_addr.
//       Strict compare means ties keep the lower index.
//     - If rom_addr==CB_SIZE-1, go DONE; otherwise rom_addr<=rom_addr+1.
//   DONE (one cycle): best_index<=best, best_error<=min_err; done_cbsearch=1 for exactly 1 cycle.
//     Next edge: busy<=0, done_cbsearch<=0, rom_addr<=0, IDLE.
//   Latency: done_cbsearch high during cycle CB_SIZE+1 after the start edge, i.e. 9 cycles.
//     Next start is accepted 1 cycle after done.
//   best_index/best_error are updated only in DONE; they stay stable during a new search.
//   start_cbsearch while busy (SEARCH/DONE) is ignored; there is no queueing. A held-high start re-triggers in IDLE.
//   target changes after the start edge have no effect on the search in progress.
//   Reset mid-search: immediate return to IDLE with reset values; no done pulse; partial result discarded.
//   Saturated case: if every entry saturates, the result is best_index=0, best_error=32'h7FFF_FFFF.
//   Codebook contents (for reference values): 2500.0 to 3200.0 in steps of 100.0 (0x09C40000..0x0C800000).
// TESTING
//   T1 exact hit: target=0x09C40000 (2500.0) -> best_index=0, best_error=0, done 9 cycles after start.
//   T2 tie: target=0x0A5A0000 (2650.0) -> best_index=1 (lower index wins), best_error=0x00320000 (50.0).
//   T3 above range: target=0x0FA00000 (4000.0) -> best_index=7, best_error=0x03200000 (800.0).
//   T4 negative/saturation:
//     - target=0xFC180000 (-1000.0) -> best_index=0, best_error=0x0DAC0000.
//     - target=0x80000000 -> best_index=0, best_error=0x7FFFFFFF.
//   T5 protocol: start pulsed again at cycle 3 of a search -> ignored; exactly one done pulse.
//     busy drops the cycle after done. rom_addr sequence is 0,1,..,7.
//   T6 reset mid-search: rst_n low at cycle 4 -> outputs at reset values, no done pulse.
//     A new start after reset completes normally with the correct result.

Source files
------------

// File: rtl/cb8_search.sv
// Codebook search engine: scans the external cb8 ROM one entry per clock and
// reports the index whose value is nearest the latched target, with its saturated error.
module cb8_search #(
    parameter int N       = 32,
    parameter int CB_SIZE = 8,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_cbsearch,
    input  logic [N-1:0]      target,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [N-1:0]      rom_data,
    output logic              busy,
    output logic [ADDR_W-1:0] best_index,
    output logic [N-1:0]      best_error,
    output logic              done_cbsearch
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [N-1:0]      ERR_MAX   = {1'b0, {(N-1){1'b1}}};
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CB_SIZE - 1);

    state_t             state_reg, state_next;
    logic [N-1:0]       target_reg, target_next;
    logic [N-1:0]       min_err_reg, min_err_next;
    logic [N-1:0]       best_error_reg, best_error_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [ADDR_W-1:0]  best_reg, best_next;
    logic [ADDR_W-1:0]  best_index_reg, best_index_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    // One extra bit keeps target - rom_data exact for any pair of signed N-bit values.
    logic [N:0]         diff;
    logic [N:0]         mag;
    logic [N-1:0]       err;
    logic               err_better;

    assign diff       = {target_reg[N-1], target_reg} - {rom_data[N-1], rom_data};
    assign mag        = diff[N] ? (~diff + 1'b1) : diff;
    assign err        = (mag > {1'b0, ERR_MAX}) ? ERR_MAX : mag[N-1:0];
    // Strict compare: on a tie the earlier (lower) index is kept.
    assign err_better = (err < min_err_reg);

    always_comb begin
        state_next      = state_reg;
        target_next     = target_reg;
        min_err_next    = min_err_reg;
        best_error_next = best_error_reg;
        addr_next       = addr_reg;
        best_next       = best_reg;
        best_index_next = best_index_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_cbsearch) begin
                    target_next  = target;
                    addr_next    = '0;
                    min_err_next = ERR_MAX;
                    best_next    = '0;
                    busy_next    = 1'b1;
                    state_next   = SEARCH;
                end
            end
            SEARCH: begin
                if (err_better) begin
                    min_err_next = err;
                    best_next    = addr_reg;
                end
                if (addr_reg == LAST_ADDR) begin
                    // Publish on the last compare so the result is valid alongside the done pulse.
                    best_index_next = err_better ? addr_reg : best_reg;
                    best_error_next = err_better ? err : min_err_reg;
                    done_next       = 1'b1;
                    state_next      = DONE;
                end else begin
                    addr_next = addr_reg + 1'b1;
                end
            end
            DONE: begin
                busy_next  = 1'b0;
                addr_next  = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            target_reg     <= '0;
            min_err_reg    <= '0;
            best_error_reg <= '0;
            addr_reg       <= '0;
            best_reg       <= '0;
            best_index_reg <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            target_reg     <= target_next;
            min_err_reg    <= min_err_next;
            best_error_reg <= best_error_next;
            addr_reg       <= addr_next;
            best_reg       <= best_next;
            best_index_reg <= best_index_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    assign rom_addr      = addr_reg;
    assign busy          = busy_reg;
    assign best_index    = best_index_reg;
    assign best_error    = best_error_reg;
    assign done_cbsearch = done_reg;

endmodule

// File: tb/tb_cb8_search.sv
// Directed bench for cb8_search: table of targets with hand-computed nearest
// entries, plus protocol, ignored-start and mid-search reset sequences.
module tb_cb8_search;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_cbsearch = 1'b0;
    logic [31:0] target = '0;
    logic [3:0]  rom_addr;
    logic [31:0] rom_data;
    logic        busy;
    logic [3:0]  best_index;
    logic [31:0] best_error;
    logic        done_cbsearch;

    int total = 0;
    int bad   = 0;

    cb8_search dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_cbsearch (start_cbsearch),
        .target         (target),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .busy           (busy),
        .best_index     (best_index),
        .best_error     (best_error),
        .done_cbsearch  (done_cbsearch)
    );

    always #5 clk = ~clk;

    // Codebook: 2500.0 + 100.0*addr in Q15.16.
    always_comb rom_data = 32'h09C4_0000 + 32'h0064_0000 * {28'd0, rom_addr};

    typedef struct {
        logic [31:0] tgt;
        logic [3:0]  exp_idx;
        logic [31:0] exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts a search, scrambles target afterwards, and returns edges from start edge to done.
    task automatic run_search(input logic [31:0] t, output int lat);
        @(negedge clk);
        start_cbsearch = 1'b1;
        target = t;
        @(posedge clk);
        #1;
        start_cbsearch = 1'b0;
        target = ~t;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (done_cbsearch) break;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rom_addr"}, {28'd0, rom_addr}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_best_index"}, {28'd0, best_index}, 32'd0);
        check({tag, "_best_error"}, best_error, 32'd0);
        check({tag, "_done"}, {31'd0, done_cbsearch}, 32'd0);
    endtask

    initial begin
        int lat;
        int dones;
        logic [3:0] prev_idx;

        vecs[0] = '{32'h09C4_0000, 4'd0, 32'h0000_0000}; // exact hit 2500
        vecs[1] = '{32'h0A5A_0000, 4'd1, 32'h0032_0000}; // tie 2650 -> lower index
        vecs[2] = '{32'h0FA0_0000, 4'd7, 32'h0320_0000}; // 4000 above range
        vecs[3] = '{32'hFC18_0000, 4'd0, 32'h0DAC_0000}; // -1000
        vecs[4] = '{32'h8000_0000, 4'd0, 32'h7FFF_FFFF}; // every entry saturates
        vecs[5] = '{32'h0C80_0000, 4'd7, 32'h0000_0000}; // exact hit last entry
        vecs[6] = '{32'h0A28_0001, 4'd1, 32'h0000_0001}; // 2600 + 1 lsb
        vecs[7] = '{32'h7FFF_FFFF, 4'd7, 32'h737F_FFFF}; // max positive
        vecs[8] = '{32'h0B53_FFFF, 4'd4, 32'h0000_0001}; // 2900 - 1 lsb

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("post_reset");

        for (int i = 0; i < 9; i++) begin
            run_search(vecs[i].tgt, lat);
            $display("txn %0d: target=%h index=%0d error=%h latency=%0d",
                     i, vecs[i].tgt, best_index, best_error, lat);
            check($sformatf("v%0d_latency", i), lat, 32'd8);
            check($sformatf("v%0d_index", i), {28'd0, best_index}, {28'd0, vecs[i].exp_idx});
            check($sformatf("v%0d_error", i), best_error, vecs[i].exp_err);
            check($sformatf("v%0d_busy_at_done", i), {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_drop", i), {31'd0, done_cbsearch}, 32'd0);
            check($sformatf("v%0d_busy_drop", i), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d_index_held", i), {28'd0, best_index}, {28'd0, vecs[i].exp_idx});
        end
        prev_idx = vecs[8].exp_idx;

        // Protocol: address sequence, held result, re-start at cycle 3 ignored
        @(negedge clk);
        start_cbsearch = 1'b1;
        target = 32'h0A8C_0000; // 2700 -> index 2
        @(posedge clk);
        #1;
        start_cbsearch = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("seq_addr%0d", k), {28'd0, rom_addr}, k);
            check($sformatf("seq_busy%0d", k), {31'd0, busy}, 32'd1);
            check($sformatf("seq_held%0d", k), {28'd0, best_index}, {28'd0, prev_idx});
            if (done_cbsearch) dones++;
            start_cbsearch = (k == 2);
            @(posedge clk);
            #1;
        end
        start_cbsearch = 1'b0;
        check("seq_done", {31'd0, done_cbsearch}, 32'd1);
        check("seq_index", {28'd0, best_index}, 32'd2);
        check("seq_error", best_error, 32'd0);
        $display("txn seq: target=0a8c0000 index=%0d error=%h", best_index, best_error);
        for (int k = 0; k < 14; k++) begin
            if (done_cbsearch) dones++;
            @(posedge clk);
            #1;
        end
        check("seq_done_count", dones, 32'd1);
        check("seq_idle_busy", {31'd0, busy}, 32'd0);

        // Reset mid-search
        @(negedge clk);
        start_cbsearch = 1'b1;
        target = 32'h09C4_0000;
        @(posedge clk);
        #1;
        start_cbsearch = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        dones = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done_cbsearch) dones++;
        end
        check("midrst_no_done", dones, 32'd0);
        $display("txn midrst: aborted, done pulses=%0d", dones);

        run_search(32'h0BB8_0000, lat); // 3000 -> index 5
        $display("txn after_rst: target=0bb80000 index=%0d error=%h latency=%0d",
                 best_index, best_error, lat);
        check("after_rst_latency", lat, 32'd8);
        check("after_rst_index", {28'd0, best_index}, 32'd5);
        check("after_rst_error", best_error, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
